// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer that decodes the opcode once
// per instruction, holds datapath controls stable, stalls on memory handshakes and flags illegal ops.
module multicycle_control_unit #(
  parameter int OPCODE_W = 4,
  parameter int ALU_OP_W = 4,
  parameter int STATE_W  = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] op_code,
  input  logic                imem_ready,
  input  logic                mem_ready,
  input  logic                alu_zero,
  output logic [STATE_W-1:0]  state,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                reg_dst,
  output logic                alu_src,
  output logic                mem_to_reg,
  output logic                jump,
  output logic                beq,
  output logic                bne,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [1:0]          mem_op,
  output logic                reg_write,
  output logic                illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_reg_dst;
  logic        r_alu_src;
  logic        r_mem_to_reg;
  logic        r_jump;
  logic        r_beq;
  logic        r_bne;
  logic        r_store;
  logic [3:0]  r_alu_op;
  logic [1:0]  r_pc_src;
  logic [1:0]  r_mem_op;
  logic        r_reg_write;
  logic        r_illegal;

  logic [31:0] w_op32;
  logic [3:0]  w_op4;
  logic        w_illegal;
  logic [3:0]  w_dec_alu;
  logic        w_dec_reg_dst;
  logic        w_dec_alu_src;
  logic        w_dec_mem_to_reg;
  logic        w_dec_jump;
  logic        w_dec_beq;
  logic        w_dec_bne;
  logic        w_dec_store;
  logic [1:0]  w_dec_pc_src;
  logic        w_take_pc;

  assign w_op32    = 32'(op_code);
  assign w_op4     = w_op32[3:0];
  assign w_illegal = (w_op32 >= 32'd16);

  always_comb begin
    w_dec_alu        = 4'd0;
    w_dec_reg_dst    = 1'b0;
    w_dec_alu_src    = 1'b0;
    w_dec_mem_to_reg = 1'b0;
    w_dec_jump       = 1'b0;
    w_dec_beq        = 1'b0;
    w_dec_bne        = 1'b0;
    w_dec_store      = 1'b0;
    case (w_op4)
      4'd0:  w_dec_reg_dst = 1'b1;
      4'd1:  w_dec_alu_src = 1'b1;
      4'd2:  begin w_dec_alu = 4'd1; w_dec_reg_dst = 1'b1; end
      4'd3:  begin w_dec_alu = 4'd1; w_dec_alu_src = 1'b1; end
      4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
        w_dec_alu     = w_op4 - 4'd2;
        w_dec_reg_dst = 1'b1;
      end
      4'd9:  w_dec_alu = 4'd7;
      4'd10: begin w_dec_alu = 4'd8; w_dec_alu_src = 1'b1; end
      4'd11: begin w_dec_alu_src = 1'b1; w_dec_mem_to_reg = 1'b1; end
      4'd12: w_dec_store = 1'b1;
      4'd13: begin w_dec_alu = 4'd1; w_dec_beq = 1'b1; end
      4'd14: begin w_dec_alu = 4'd1; w_dec_bne = 1'b1; end
      default: w_dec_jump = 1'b1;
    endcase
  end

  always_comb begin
    w_dec_pc_src = 2'd0;
    if (w_illegal)                    w_dec_pc_src = 2'd0;
    else if (w_dec_jump)              w_dec_pc_src = 2'd2;
    else if (w_dec_beq || w_dec_bne)  w_dec_pc_src = 2'd1;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = imem_ready ? S_DECODE : S_FETCH;
      S_DECODE: w_next = w_illegal ? S_FETCH : S_EXEC;
      S_EXEC: begin
        if (r_mem_to_reg || r_store)        w_next = S_MEM;
        else if (r_jump || r_beq || r_bne)  w_next = S_FETCH;
        else                                w_next = S_WB;
      end
      S_MEM: begin
        if (!mem_ready)        w_next = S_MEM;
        else if (r_mem_to_reg) w_next = S_WB;
        else                   w_next = S_FETCH;
      end
      S_WB:    w_next = S_FETCH;
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Controls are captured at the end of DECODE and dropped on the edge that returns to FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_reg_dst    <= 1'b0;
      r_alu_src    <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_jump       <= 1'b0;
      r_beq        <= 1'b0;
      r_bne        <= 1'b0;
      r_store      <= 1'b0;
      r_alu_op     <= 4'd0;
    end else if (w_next == S_FETCH) begin
      r_reg_dst    <= 1'b0;
      r_alu_src    <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_jump       <= 1'b0;
      r_beq        <= 1'b0;
      r_bne        <= 1'b0;
      r_store      <= 1'b0;
      r_alu_op     <= 4'd0;
    end else if (r_state == S_DECODE) begin
      r_reg_dst    <= w_dec_reg_dst;
      r_alu_src    <= w_dec_alu_src;
      r_mem_to_reg <= w_dec_mem_to_reg;
      r_jump       <= w_dec_jump;
      r_beq        <= w_dec_beq;
      r_bne        <= w_dec_bne;
      r_store      <= w_dec_store;
      r_alu_op     <= w_dec_alu;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc_src    <= 2'd0;
      r_mem_op    <= 2'b00;
      r_reg_write <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_pc_src    <= (w_next == S_EXEC) ? w_dec_pc_src : 2'd0;
      r_mem_op    <= (w_next != S_MEM) ? 2'b00 : (r_mem_to_reg ? 2'b01 : 2'b10);
      r_reg_write <= (w_next == S_WB);
      r_illegal   <= r_illegal | ((r_state == S_DECODE) & w_illegal);
    end
  end

  // Fetch and branch strobes qualify the registered state with the handshake/flag of the
  // same cycle so the PC and IR load on the edge that leaves that state.
  assign w_take_pc = r_jump | (r_beq & alu_zero) | (r_bne & ~alu_zero);

  assign ir_write   = ~reset & (r_state == S_FETCH) & imem_ready;
  assign pc_write   = ~reset & (((r_state == S_FETCH) & imem_ready) |
                                ((r_state == S_EXEC) & w_take_pc));
  assign state      = STATE_W'(r_state);
  assign pc_src     = r_pc_src;
  assign reg_dst    = r_reg_dst;
  assign alu_src    = r_alu_src;
  assign mem_to_reg = r_mem_to_reg;
  assign jump       = r_jump;
  assign beq        = r_beq;
  assign bne        = r_bne;
  assign alu_op     = ALU_OP_W'(r_alu_op);
  assign mem_op     = r_mem_op;
  assign reg_write  = r_reg_write;
  assign illegal    = r_illegal;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit (5-bit opcode build so illegal codes are reachable).
module tb_multicycle_control_unit;

  logic       clk;
  logic       reset;
  logic [4:0] op_code;
  logic       imem_ready;
  logic       mem_ready;
  logic       alu_zero;
  logic [2:0] state;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       reg_dst;
  logic       alu_src;
  logic       mem_to_reg;
  logic       jump;
  logic       beq;
  logic       bne;
  logic [3:0] alu_op;
  logic [1:0] mem_op;
  logic       reg_write;
  logic       illegal;

  int checks   = 0;
  int failures = 0;

  multicycle_control_unit #(.OPCODE_W(5), .ALU_OP_W(4), .STATE_W(3)) dut (
    .clk(clk), .reset(reset), .op_code(op_code), .imem_ready(imem_ready),
    .mem_ready(mem_ready), .alu_zero(alu_zero), .state(state), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .reg_dst(reg_dst), .alu_src(alu_src),
    .mem_to_reg(mem_to_reg), .jump(jump), .beq(beq), .bne(bne), .alu_op(alu_op),
    .mem_op(mem_op), .reg_write(reg_write), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and confirm the two write strobes never overlap.
  task automatic step();
    @(negedge clk);
    check("strobe_overlap", 32'(pc_write & reg_write), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b1; op_code = 5'd0; imem_ready = 1'b1; mem_ready = 1'b1; alu_zero = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(state), 32'd0);
    check("rst_ir_write", 32'(ir_write), 32'd0);
    check("rst_pc_write", 32'(pc_write), 32'd0);
    check("rst_reg_write", 32'(reg_write), 32'd0);
    check("rst_mem_op", 32'(mem_op), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);

    // R-type op 0: FETCH, DECODE, EXEC, WB
    reset = 1'b0;
    #1;
    check("t1_fetch_state", 32'(state), 32'd0);
    check("t1_fetch_ir_write", 32'(ir_write), 32'd1);
    check("t1_fetch_pc_write", 32'(pc_write), 32'd1);
    check("t1_fetch_pc_src", 32'(pc_src), 32'd0);
    step();
    check("t1_decode_state", 32'(state), 32'd1);
    check("t1_decode_pc_write", 32'(pc_write), 32'd0);
    check("t1_decode_reg_write", 32'(reg_write), 32'd0);
    step();
    check("t1_exec_state", 32'(state), 32'd2);
    check("t1_exec_reg_dst", 32'(reg_dst), 32'd1);
    check("t1_exec_alu_op", 32'(alu_op), 32'd0);
    check("t1_exec_reg_write", 32'(reg_write), 32'd0);
    step();
    check("t1_wb_state", 32'(state), 32'd4);
    check("t1_wb_reg_write", 32'(reg_write), 32'd1);
    step();
    check("t1_end_state", 32'(state), 32'd0);
    check("t1_end_reg_write", 32'(reg_write), 32'd0);
    check("t1_end_reg_dst", 32'(reg_dst), 32'd0);

    // Load op 11 with three stalled MEM cycles; op_code changes mid-instruction
    op_code = 5'd11; mem_ready = 1'b0;
    step();
    check("t2_decode_state", 32'(state), 32'd1);
    step();
    check("t2_exec_state", 32'(state), 32'd2);
    check("t2_exec_mem_to_reg", 32'(mem_to_reg), 32'd1);
    check("t2_exec_alu_src", 32'(alu_src), 32'd1);
    check("t2_exec_mem_op", 32'(mem_op), 32'd0);
    step();
    check("t2_mem1_state", 32'(state), 32'd3);
    check("t2_mem1_mem_op", 32'(mem_op), 32'd1);
    op_code = 5'd3;
    step();
    check("t2_mem2_mem_op", 32'(mem_op), 32'd1);
    step();
    check("t2_mem3_mem_op", 32'(mem_op), 32'd1);
    step();
    check("t2_mem4_state", 32'(state), 32'd3);
    check("t2_mem4_mem_op", 32'(mem_op), 32'd1);
    mem_ready = 1'b1;
    step();
    check("t2_wb_state", 32'(state), 32'd4);
    check("t2_wb_reg_write", 32'(reg_write), 32'd1);
    check("t2_wb_mem_op", 32'(mem_op), 32'd0);
    check("t2_wb_mem_to_reg", 32'(mem_to_reg), 32'd1);
    check("t2_wb_alu_op", 32'(alu_op), 32'd0);
    step();
    check("t2_end_state", 32'(state), 32'd0);

    // beq taken, beq not taken, bne taken
    op_code = 5'd13; alu_zero = 1'b1;
    step(); step();
    check("t3_beq_state", 32'(state), 32'd2);
    check("t3_beq_pc_write", 32'(pc_write), 32'd1);
    check("t3_beq_pc_src", 32'(pc_src), 32'd1);
    check("t3_beq_flag", 32'(beq), 32'd1);
    check("t3_beq_alu_op", 32'(alu_op), 32'd1);
    step();
    check("t3_beq_end_state", 32'(state), 32'd0);
    alu_zero = 1'b0;
    step(); step();
    check("t3_beqnt_state", 32'(state), 32'd2);
    check("t3_beqnt_pc_write", 32'(pc_write), 32'd0);
    step();
    check("t3_beqnt_end_state", 32'(state), 32'd0);
    op_code = 5'd14;
    step(); step();
    check("t3_bne_pc_write", 32'(pc_write), 32'd1);
    check("t3_bne_flag", 32'(bne), 32'd1);
    step();
    check("t3_bne_end_state", 32'(state), 32'd0);

    // Jump op 15: three-cycle instruction
    op_code = 5'd15;
    step(); step();
    check("t4_jump_flag", 32'(jump), 32'd1);
    check("t4_jump_pc_src", 32'(pc_src), 32'd2);
    check("t4_jump_pc_write", 32'(pc_write), 32'd1);
    check("t4_jump_reg_write", 32'(reg_write), 32'd0);
    step();
    check("t4_end_state", 32'(state), 32'd0);
    check("t4_end_jump", 32'(jump), 32'd0);

    // I-type op 10
    op_code = 5'd10;
    step(); step();
    check("ti_alu_op", 32'(alu_op), 32'd8);
    check("ti_alu_src", 32'(alu_src), 32'd1);
    check("ti_reg_dst", 32'(reg_dst), 32'd0);
    step();
    check("ti_wb_state", 32'(state), 32'd4);
    step();

    // Illegal op 17, then a normal op 2
    op_code = 5'd17;
    step();
    check("t5_decode_state", 32'(state), 32'd1);
    step();
    check("t5_back_state", 32'(state), 32'd0);
    check("t5_illegal", 32'(illegal), 32'd1);
    check("t5_alu_op", 32'(alu_op), 32'd0);
    check("t5_reg_write", 32'(reg_write), 32'd0);
    op_code = 5'd2;
    step(); step();
    check("t5_next_state", 32'(state), 32'd2);
    check("t5_next_alu_op", 32'(alu_op), 32'd1);
    check("t5_next_reg_dst", 32'(reg_dst), 32'd1);
    check("t5_sticky", 32'(illegal), 32'd1);
    step(); step();
    check("t5_end_illegal", 32'(illegal), 32'd1);

    // Store op 12, reset asserted asynchronously during MEM
    op_code = 5'd12; mem_ready = 1'b0;
    step(); step(); step();
    check("t6_mem_state", 32'(state), 32'd3);
    check("t6_mem_op", 32'(mem_op), 32'd2);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_mem_op", 32'(mem_op), 32'd0);
    check("t6_rst_state", 32'(state), 32'd0);
    check("t6_rst_illegal", 32'(illegal), 32'd0);
    check("t6_rst_pc_write", 32'(pc_write), 32'd0);
    @(negedge clk);
    reset = 1'b0; imem_ready = 1'b0; mem_ready = 1'b1;
    step();
    check("t6_hold_state", 32'(state), 32'd0);
    check("t6_hold_ir_write", 32'(ir_write), 32'd0);
    check("t6_hold_pc_write", 32'(pc_write), 32'd0);
    imem_ready = 1'b1;
    #1;
    check("t6_fetch_ir_write", 32'(ir_write), 32'd1);
    step(); step(); step();
    check("t6_store_mem_op", 32'(mem_op), 32'd2);
    check("t6_store_reg_write", 32'(reg_write), 32'd0);
    step();
    check("t6_store_end_state", 32'(state), 32'd0);
    check("t6_store_end_mem_op", 32'(mem_op), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
